// File: rtl/perf_evt_pacer.sv
// perf_evt_pacer: meters multi-bit per-cycle event counts out as single-cycle
// pulses, one per lane per cycle. Each lane keeps its backlog in a saturating
// pending counter and has a sticky overflow flag for counts that were lost.
module perf_evt_pacer #(
  parameter int NumEvents = 8,
  parameter int CntWidth  = 2,
  parameter int PendWidth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic                          hold_i,
  input  logic                          clear_i,
  input  logic [NumEvents*CntWidth-1:0] evt_cnt_i,
  output logic [NumEvents-1:0]          evt_o,
  output logic [NumEvents-1:0]          ovf_o,
  output logic                          busy_o
);

  // One bit wider than the wider operand, so pending + input can never wrap.
  localparam int SumWidth = ((PendWidth > CntWidth) ? PendWidth : CntWidth) + 1;
  localparam logic [SumWidth-1:0] PMax =
    {{(SumWidth-PendWidth){1'b0}}, {PendWidth{1'b1}}};

  logic [NumEvents-1:0][PendWidth-1:0] r_pend;
  logic [NumEvents-1:0]                r_evt;
  logic [NumEvents-1:0]                r_ovf;

  logic [NumEvents-1:0][CntWidth-1:0]  w_in;
  logic [NumEvents-1:0][SumWidth-1:0]  w_sum;
  logic [NumEvents-1:0][SumWidth-1:0]  w_nxt;
  logic [NumEvents-1:0][PendWidth-1:0] w_pend_d;
  logic [NumEvents-1:0]                w_evt_d;
  logic [NumEvents-1:0]                w_ovf_d;

  // Per-lane next state: clear beats debug/hold, which beat emission.
  always_comb begin
    w_in     = '0;
    w_sum    = '0;
    w_nxt    = '0;
    w_pend_d = '0;
    w_evt_d  = '0;
    w_ovf_d  = '0;
    for (int e = 0; e < NumEvents; e++) begin
      // New counts are dropped while the core is in debug mode.
      if (debug_mode_i) begin
        w_in[e] = {CntWidth{1'b0}};
      end else begin
        w_in[e] = evt_cnt_i[e*CntWidth +: CntWidth];
      end
      w_sum[e] = SumWidth'(r_pend[e]) + SumWidth'(w_in[e]);

      if (clear_i) begin
        w_evt_d[e] = 1'b0;
        w_nxt[e]   = {SumWidth{1'b0}};
      end else if (debug_mode_i || hold_i) begin
        // Backlog is kept; under hold the input is still accumulated.
        w_evt_d[e] = 1'b0;
        w_nxt[e]   = w_sum[e];
      end else begin
        w_evt_d[e] = (w_sum[e] != {SumWidth{1'b0}});
        w_nxt[e]   = w_sum[e] - {{(SumWidth-1){1'b0}}, w_evt_d[e]};
      end

      // Saturate after the decrement so a full counter emitting one pulse
      // while receiving one count does not flag a loss.
      if (w_nxt[e] > PMax) begin
        w_pend_d[e] = {PendWidth{1'b1}};
      end else begin
        w_pend_d[e] = w_nxt[e][PendWidth-1:0];
      end

      if (clear_i) begin
        w_ovf_d[e] = 1'b0;
      end else begin
        w_ovf_d[e] = r_ovf[e] | (w_nxt[e] > PMax);
      end
    end
  end

  // Lane state registers; asynchronous reset discards all backlog at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_evt  <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= w_pend_d;
      r_evt  <= w_evt_d;
      r_ovf  <= w_ovf_d;
    end
  end

  assign evt_o  = r_evt;
  assign ovf_o  = r_ovf;
  assign busy_o = |r_pend;

endmodule
